sm_para_arb: RTL and testbench
==============================

// Module: sm_para_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one sm_para FSM instance among NREQ requesters.
//  Each requester streams (i1,i2) symbol bursts. This block grants one burst at a time and drives the FSM inputs and its nrst.
//  It returns the FSM's o1/o2/err per symbol to the owner. On FSM err it aborts the burst and re-initialises the FSM.
//  Sits between requester logic and the shared sm_para_* core.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  RST_CYC  2   cycles fsm_nrst held low on init/recovery (>=1)
//  TMO      8   idle cycles a granted requester may stall before grant is revoked (>=1)
//  CNT_W    8   width of saturating error counter
// PORTS
//  clk        in   1        clock, all logic on posedge
//  rst        in   1        async reset, active-high
//  req_valid  in   NREQ     requester i has a symbol
//  req_sym    in   2*NREQ   {i1,i2} of requester i at bits [2i+1:2i]
//  req_last   in   NREQ     symbol is last of burst
//  req_ready  out  NREQ     symbol accepted when valid&ready; one-hot or zero
//  fsm_nrst   out  1        reset to FSM, active-low, registered
//  fsm_i1     out  1        FSM input i1, registered
//  fsm_i2     out  1        FSM input i2, registered
//  fsm_o1     in   1        FSM output o1
//  fsm_o2     in   1        FSM output o2
//  fsm_err    in   1        FSM error flag
//  rsp_valid  out  1        response strobe, one cycle
//  rsp_id     out  clog2(NREQ) owner of response
//  rsp_o      out  2        {o1,o2} sampled
//  rsp_err    out  1        err sampled (burst aborted)
//  gnt        out  NREQ     current grant, one-hot or zero
//  tmo_evt    out  1        one-cycle pulse when grant revoked by timeout
//  err_cnt    out  CNT_W    saturating count of aborted bursts
// BEHAVIOUR
//  Reset values: all outputs 0 (fsm_nrst=0, gnt=0, err_cnt=0); rr pointer=NREQ-1; state=INIT.
//  States: INIT -> IDLE -> XFER -> (IDLE | RECOVER); RECOVER -> IDLE.
//  INIT/RECOVER: fsm_nrst=0 for exactly RST_CYC cycles, then 1; req_ready=0, gnt=0.
//  IDLE: if any req_valid, pick first valid searching ptr+1, ptr+2,... mod NREQ; gnt registered, XFER next cycle.
//    No valid: stay IDLE.
//  XFER: req_ready[g]=gnt[g]. Accept at cycle n -> fsm_i1/i2=sym from cycle n+1.
//    FSM outputs sampled in cycle n+2: rsp_valid=1, rsp_id=g, rsp_o={fsm_o1,fsm_o2}, rsp_err=fsm_err.
//  fsm_i1/i2 hold last value when no symbol accepted; not cleared on burst end (only on rst).
//  Back-to-back beats allowed: one symbol per cycle, 2-deep response pipeline (valid+id per stage).
//  Accept with req_last=1: ready drops next cycle, ptr<=g, IDLE; in-flight responses still delivered.
//  Abort: response with fsm_err=1 -> that rsp delivered with rsp_err=1; same cycle req_ready forced 0.
//    Younger in-flight responses flushed (no rsp_valid). err_cnt+1 (saturates at all-ones).
//    ptr<=g; RECOVER next cycle.
//  err wins over last accepted same cycle; err on a flushed beat is ignored.
//  Timeout: in XFER, stall counter counts cycles with req_valid[g]=0. Reaching TMO -> tmo_evt pulse, ptr<=g, IDLE.
//    Any accept clears the counter. In-flight responses still delivered.
//  Responses never issued while fsm_nrst=0; fsm_err ignored unless a response stage is valid.
//  rst asserted mid-operation: immediate return to reset values regardless of state; INIT follows release.
// TESTING
//  1 rst high 3 cyc, release -> fsm_nrst=0 for 2 cyc then 1; gnt=0, req_ready=0, rsp_valid=0 throughout.
//  2 req0 burst 11,01,10(last), err=0 -> gnt=0001; 3 rsp_valid, rsp_id=0, each 2 cyc after accept; then IDLE.
//  3 after grant to req0, req0 and req2 valid together -> req2 granted first, then req0 (ptr search from 1).
//  4 req1 burst of 3, fsm_err=1 on 2nd rsp -> rsp_err=1 once, 3rd rsp suppressed, fsm_nrst low 2 cyc, err_cnt=1.
//  5 req3 granted, valid held 0 for 8 cyc -> tmo_evt pulse on 8th, gnt=0, next requester arbitrated.
//  6 rst mid-burst of req0 -> outputs zero asynchronously; after release INIT 2 cyc, no stale rsp_valid.

Source files
------------

// File: rtl/sm_para_arb_if.sv
// Bundle between burst requesters, the sm_para_arb sequencer and the shared sm_para FSM.
// slave = arbiter side, master = requesters plus FSM core side.
interface sm_para_arb_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_sym;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fsm_nrst;
  logic              fsm_i1;
  logic              fsm_i2;
  logic              fsm_o1;
  logic              fsm_o2;
  logic              fsm_err;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_o;
  logic              rsp_err;
  logic [NREQ-1:0]   gnt;
  logic              tmo_evt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output req_valid, req_sym, req_last, fsm_o1, fsm_o2, fsm_err,
    input  req_ready, fsm_nrst, fsm_i1, fsm_i2, rsp_valid, rsp_id, rsp_o, rsp_err,
           gnt, tmo_evt, err_cnt
  );

  modport slave (
    input  req_valid, req_sym, req_last, fsm_o1, fsm_o2, fsm_err,
    output req_ready, fsm_nrst, fsm_i1, fsm_i2, rsp_valid, rsp_id, rsp_o, rsp_err,
           gnt, tmo_evt, err_cnt
  );
endinterface

// File: rtl/sm_para_arb.sv
// Round-robin sequencer sharing one sm_para FSM among NREQ burst requesters.
// Responses return 2 cycles after accept; an FSM error aborts the burst and re-initialises the FSM.
module sm_para_arb #(
  parameter int NREQ    = 4,
  parameter int RST_CYC = 2,
  parameter int TMO     = 8,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  sm_para_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int SCW = $clog2(TMO + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_XFER, S_RECOVER} state_t;

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IDW-1:0]   r_gid;
  logic [IDW-1:0]   r_ptr;
  logic             r_s1_vld;
  logic [IDW-1:0]   r_s1_id;
  logic             r_s2_vld;
  logic [IDW-1:0]   r_s2_id;
  logic             r_nrst;
  logic             r_fsm_i1;
  logic             r_fsm_i2;
  logic             r_tmo;
  logic [RCW-1:0]   r_rcnt;
  logic [SCW-1:0]   r_stall;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_rsp;
  logic             w_abort;
  logic             w_acc;
  logic             w_sel_vld;
  logic [IDW-1:0]   w_sel;
  logic [IDW-1:0]   w_idx;
  logic [1:0]       w_sym;

  always_comb begin
    w_rsp   = r_s2_vld && r_nrst;
    w_abort = w_rsp && bus.fsm_err;
    w_acc   = (r_state == S_XFER) && !w_abort && bus.req_valid[r_gid];
    w_sym   = bus.req_sym[{r_gid, 1'b0} +: 2];
    // Walk downwards so the nearest valid requester after the pointer wins.
    w_sel_vld = 1'b0;
    w_sel     = r_ptr;
    w_idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_sel_vld = 1'b1;
        w_sel     = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_gnt     <= '0;
      r_gid     <= '0;
      r_ptr     <= IDW'(NREQ - 1);
      r_s1_vld  <= 1'b0;
      r_s1_id   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_id   <= '0;
      r_nrst    <= 1'b0;
      r_fsm_i1  <= 1'b0;
      r_fsm_i2  <= 1'b0;
      r_tmo     <= 1'b0;
      r_rcnt    <= '0;
      r_stall   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_tmo    <= 1'b0;
      r_s1_vld <= w_acc;
      r_s1_id  <= r_gid;
      r_s2_vld <= r_s1_vld && !w_abort;
      r_s2_id  <= r_s1_id;
      if (w_acc) begin
        r_fsm_i1 <= w_sym[1];
        r_fsm_i2 <= w_sym[0];
      end

      // The abort attributes to the owner of the failing response, which may differ from the current grant.
      if (w_abort) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        r_ptr   <= r_s2_id;
        r_gnt   <= '0;
        r_nrst  <= 1'b0;
        r_rcnt  <= '0;
        r_state <= S_RECOVER;
      end else begin
        case (r_state)
          S_INIT, S_RECOVER: begin
            if (r_rcnt == RCW'(RST_CYC - 1)) begin
              r_nrst  <= 1'b1;
              r_rcnt  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (w_sel_vld) begin
              r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
              r_gid   <= w_sel;
              r_stall <= '0;
              r_state <= S_XFER;
            end
          end
          S_XFER: begin
            if (w_acc) begin
              r_stall <= '0;
              if (bus.req_last[r_gid]) begin
                r_ptr   <= r_gid;
                r_gnt   <= '0;
                r_state <= S_IDLE;
              end
            end else if (!bus.req_valid[r_gid]) begin
              if (r_stall == SCW'(TMO - 1)) begin
                r_tmo   <= 1'b1;
                r_ptr   <= r_gid;
                r_gnt   <= '0;
                r_stall <= '0;
                r_state <= S_IDLE;
              end else begin
                r_stall <= r_stall + 1'b1;
              end
            end
          end
          default: r_state <= S_INIT;
        endcase
      end
    end
  end

  assign bus.req_ready = (r_state == S_XFER && !w_abort) ? r_gnt : '0;
  assign bus.fsm_nrst  = r_nrst;
  assign bus.fsm_i1    = r_fsm_i1;
  assign bus.fsm_i2    = r_fsm_i2;
  assign bus.rsp_valid = w_rsp;
  assign bus.rsp_id    = r_s2_id;
  assign bus.rsp_o     = w_rsp ? {bus.fsm_o1, bus.fsm_o2} : 2'b00;
  assign bus.rsp_err   = w_abort;
  assign bus.gnt       = r_gnt;
  assign bus.tmo_evt   = r_tmo;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_sm_para_arb.sv
// Directed bench for sm_para_arb with a registered mock FSM and a response scoreboard.
module tb_sm_para_arb;
  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [1:0]  o;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  int   err_seen = 0;
  logic err_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  logic [NREQ-1:0] g;
  int   lo;

  sm_para_arb_if #(.NREQ(NREQ), .CNT_W(8)) bus ();

  sm_para_arb #(.NREQ(NREQ), .RST_CYC(2), .TMO(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock FSM: o1 = i1, o2 = i1^i2, err on symbol 11 when armed, one cycle behind its inputs.
  always @(posedge clk) begin
    if (!bus.fsm_nrst) begin
      bus.fsm_o1  <= 1'b0;
      bus.fsm_o2  <= 1'b0;
      bus.fsm_err <= 1'b0;
    end else begin
      bus.fsm_o1  <= bus.fsm_i1;
      bus.fsm_o2  <= bus.fsm_i1 ^ bus.fsm_i2;
      bus.fsm_err <= err_en & bus.fsm_i1 & bus.fsm_i2;
    end
  end

  function automatic logic [1:0] model_o(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lo_count(output int n);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("init_gnt_zero", {28'd0, bus.gnt}, 32'd0);
      chk("init_ready_zero", {28'd0, bus.req_ready}, 32'd0);
      if (!bus.fsm_nrst) n++;
      else if (n > 0) break;
    end
  endtask

  // Drives one symbol and waits (bounded) for its acceptance; expectation queued on accept.
  task automatic send(input int id, input logic [1:0] sym, input bit last,
                      output logic [NREQ-1:0] gseen);
    bit   done;
    exp_t e;
    done  = 1'b0;
    gseen = '0;
    bus.req_valid[id]        = 1'b1;
    bus.req_sym[2*id +: 2]   = sym;
    bus.req_last[id]         = last;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        done  = 1'b1;
        gseen = bus.gnt;
        e.id  = 2'(id);
        e.o   = model_o(sym);
        e.err = err_en & (sym == 2'b11);
        e.cyc = 32'(cyc);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    chk("send_accept", {31'd0, done}, 32'd1);
    if (last) bus.req_valid[id] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!bus.fsm_nrst) chk("rsp_during_nrst_low", {31'd0, bus.rsp_valid}, 32'd0);
    if (bus.rsp_valid) begin
      rsp_seen++;
      if (bus.rsp_err) err_seen++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", {30'd0, bus.rsp_id}, {30'd0, mon_e.id});
        chk("rsp_o", {30'd0, bus.rsp_o}, {30'd0, mon_e.o});
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
        chk("rsp_latency", 32'(cyc) - mon_e.cyc, 32'd2);
        if (mon_e.err) sb.delete();
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_sym   = '0;
    bus.req_last  = '0;

    // 1: reset values and INIT duration
    repeat (3) begin
      @(negedge clk);
      chk("rst_nrst", {31'd0, bus.fsm_nrst}, 32'd0);
      chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
      chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      chk("rst_tmo", {31'd0, bus.tmo_evt}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    lo_count(lo);
    chk("init_nrst_low_cycles", 32'(lo), 32'd2);
    step();

    // 2: req0 burst of three, clean
    send(0, 2'b11, 1'b0, g);
    chk("t2_gnt", {28'd0, g}, 32'b0001);
    send(0, 2'b01, 1'b0, g);
    send(0, 2'b10, 1'b1, g);
    chk("t2_gnt_after_last", {28'd0, bus.gnt}, 32'd0);
    repeat (4) step();
    chk("t2_rsp_count", 32'(rsp_seen), 32'd3);

    // 3: req0 and req2 together, pointer at 0 -> req2 first
    bus.req_valid[0]  = 1'b1;
    bus.req_sym[1:0]  = 2'b01;
    bus.req_last[0]   = 1'b1;
    send(2, 2'b10, 1'b1, g);
    chk("t3_gnt_req2", {28'd0, g}, 32'b0100);
    send(0, 2'b01, 1'b1, g);
    chk("t3_gnt_req0", {28'd0, g}, 32'b0001);
    repeat (4) step();
    chk("t3_rsp_count", 32'(rsp_seen), 32'd5);

    // 4: req1 burst, error on second response
    err_en = 1'b1;
    send(1, 2'b01, 1'b0, g);
    chk("t4_gnt_req1", {28'd0, g}, 32'b0010);
    send(1, 2'b11, 1'b0, g);
    send(1, 2'b10, 1'b1, g);
    lo_count(lo);
    chk("t4_recover_nrst_low", 32'(lo), 32'd2);
    chk("t4_rsp_count", 32'(rsp_seen), 32'd7);
    chk("t4_err_seen", 32'(err_seen), 32'd1);
    chk("t4_err_cnt", {24'd0, bus.err_cnt}, 32'd1);
    chk("t4_sb_flushed", 32'(sb.size()), 32'd0);
    err_en = 1'b0;
    step();

    // 5: req3 granted then stalls -> timeout after 8 idle cycles
    bus.req_valid[3] = 1'b1;
    bus.req_sym[7:6] = 2'b00;
    bus.req_last[3]  = 1'b0;
    step();
    bus.req_valid[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t5_gnt_held", {28'd0, bus.gnt}, 32'b1000);
      chk("t5_tmo_quiet", {31'd0, bus.tmo_evt}, 32'd0);
    end
    @(negedge clk);
    chk("t5_tmo_pulse", {31'd0, bus.tmo_evt}, 32'd1);
    chk("t5_gnt_revoked", {28'd0, bus.gnt}, 32'd0);
    @(negedge clk);
    chk("t5_tmo_one_cycle", {31'd0, bus.tmo_evt}, 32'd0);
    step();
    bus.req_valid[2] = 1'b1;
    bus.req_sym[5:4] = 2'b11;
    bus.req_last[2]  = 1'b1;
    send(0, 2'b01, 1'b1, g);
    chk("t5_next_req0", {28'd0, g}, 32'b0001);
    send(2, 2'b11, 1'b1, g);
    chk("t5_next_req2", {28'd0, g}, 32'b0100);
    repeat (4) step();
    chk("t5_rsp_count", 32'(rsp_seen), 32'd9);

    // 6: asynchronous reset in the middle of a req0 burst
    send(0, 2'b11, 1'b0, g);
    send(0, 2'b01, 1'b0, g);
    #1 rst = 1'b1;
    #1;
    chk("t6_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("t6_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("t6_nrst", {31'd0, bus.fsm_nrst}, 32'd0);
    chk("t6_fsm_i", {30'd0, bus.fsm_i1, bus.fsm_i2}, 32'd0);
    chk("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t6_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
    sb.delete();
    bus.req_valid = '0;
    bus.req_last  = '0;
    repeat (2) step();
    rst = 1'b0;
    lo_count(lo);
    chk("t6_init_nrst_low", 32'(lo), 32'd2);
    chk("t6_no_stale_rsp", 32'(rsp_seen), 32'd9);
    step();
    send(1, 2'b10, 1'b1, g);
    chk("t6_post_gnt", {28'd0, g}, 32'b0010);
    repeat (4) step();
    chk("t6_rsp_count", 32'(rsp_seen), 32'd10);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
